// File: rtl/stimulus_loader_if.sv
// -----------------------------------------------------------------------------
// stimulus_loader_if
// Bundles the two buses of the stimulus loader:
//   - memory read port : address_out, rd_en  (loader -> memory)
//                        mem_data_in          (memory -> loader, one cycle after rd_en)
//   - stimulus stream  : stim_data, stim_valid, stim_last (loader -> DUT)
//                        stim_ready                       (DUT -> loader)
// Modports:
//   master : the loader side
//   slave  : the memory/DUT side
// -----------------------------------------------------------------------------
interface stimulus_loader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address_out;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] stim_data;
  logic                  stim_valid;
  logic                  stim_ready;
  logic                  stim_last;

  modport master (
    output address_out, rd_en, stim_data, stim_valid, stim_last,
    input  mem_data_in, stim_ready
  );

  modport slave (
    input  address_out, rd_en, stim_data, stim_valid, stim_last,
    output mem_data_in, stim_ready
  );
endinterface

// File: rtl/stimulus_loader.sv
// -----------------------------------------------------------------------------
// stimulus_loader
// On a start pulse, reads NUM_WORDS words from on-chip memory starting at
// INPUT_BASE_ADDR (address wraps mod 2**ADDR_WIDTH) and presents each one to
// the DUT over a valid/ready handshake, flagging the final word with
// stim_last. load_done pulses for one cycle once the last word is accepted.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active-high
//   start      in   one-cycle run request, honoured only when idle
//   bus        --   stimulus_loader_if.master (memory read port + stimulus stream)
//   busy       out  high from the cycle after an accepted start until load_done
//   load_done  out  one-cycle pulse after the last word is accepted
//   stim_cksum out  modular sum of transferred words (only with STIM_CKSUM_EN)
//
// Optional feature: define STIM_CKSUM_EN to add the stim_cksum port and its
// accumulator. Without it the port is absent and everything else is identical.
//
// Per word the FSM walks READ (rd_en) -> WAIT (memory latency, capture) ->
// PRESENT (valid until accepted), so the best case is one word per 3 cycles.
// All outputs are registered and are loaded on the transition into the state
// that owns them.
// -----------------------------------------------------------------------------
module stimulus_loader #(
  parameter int ADDR_WIDTH      = 11,
  parameter int DATA_WIDTH      = 16,
  parameter int INPUT_BASE_ADDR = 0,
  parameter int NUM_WORDS       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  stimulus_loader_if.master     bus,
  output logic                  busy,
  output logic                  load_done
`ifdef STIM_CKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] stim_cksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(INPUT_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] address_q;
  logic                  rd_en_q;
  logic [DATA_WIDTH-1:0] stim_data_q;
  logic                  stim_valid_q;
  logic                  stim_last_q;
`ifdef STIM_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q;
`endif

  logic transfer;
  assign transfer = stim_valid_q && bus.stim_ready;

  // NOTE: every register in this block uses non-blocking assignment so that
  // all of them see the pre-edge values of each other, exactly like flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      address_q    <= '0;
      rd_en_q      <= 1'b0;
      stim_data_q  <= '0;
      stim_valid_q <= 1'b0;
      stim_last_q  <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
`ifdef STIM_CKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      // NOTE: load_done defaults low every cycle; only the PRESENT->DONE
      // transition raises it, which makes it a single-cycle pulse.
      load_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            idx       <= '0;
            address_q <= BASE_ADDR;
            rd_en_q   <= 1'b1;
            busy      <= 1'b1;
`ifdef STIM_CKSUM_EN
            cksum_q   <= '0;
`endif
          end
        end

        READ: begin
          rd_en_q <= 1'b0;
          state   <= WAIT;
        end

        WAIT: begin
          // Memory data is valid this cycle (one cycle after rd_en).
          stim_data_q  <= bus.mem_data_in;
          stim_valid_q <= 1'b1;
          stim_last_q  <= (idx == LAST_IDX);
          state        <= PRESENT;
        end

        PRESENT: begin
          // Without a transfer everything holds, keeping data/last stable.
          if (transfer) begin
            stim_valid_q <= 1'b0;
            stim_last_q  <= 1'b0;
`ifdef STIM_CKSUM_EN
            cksum_q      <= cksum_q + stim_data_q;
`endif
            if (stim_last_q) begin
              state     <= DONE;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state     <= READ;
              idx       <= idx + 1'b1;
              // Natural ADDR_WIDTH overflow gives the required address wrap.
              address_q <= BASE_ADDR + idx + 1'b1;
              rd_en_q   <= 1'b1;
            end
          end
        end

        DONE: begin
          // start is deliberately ignored here; runs are never queued.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.address_out = address_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.stim_data   = stim_data_q;
  assign bus.stim_valid  = stim_valid_q;
  assign bus.stim_last   = stim_last_q;
`ifdef STIM_CKSUM_EN
  assign stim_cksum      = cksum_q;
`endif

endmodule

// File: tb/tb_stimulus_loader.sv
// -----------------------------------------------------------------------------
// tb_stimulus_loader
// Three loader instances share one memory model:
//   a : base 0,    4 words  (basic, backpressure, start-while-busy, reset, cksum)
//   b : base 2046, 3 words  (address wrap)
//   c : base 100,  1 word   (single-word run)
// Only the selected instance is started at any time. Expected addresses and
// words are queued from the memory contents when a run is launched and popped
// by a monitor when the selected DUT issues rd_en or completes a transfer.
// -----------------------------------------------------------------------------
module tb_stimulus_loader;

  localparam int AW = 11;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic ready;
  int   sel;

  always #5 clk = ~clk;

  stimulus_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  stimulus_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();
  stimulus_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_c ();

  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
`ifdef STIM_CKSUM_EN
  logic [DW-1:0] cksum_a, cksum_b, cksum_c;
`endif

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);
  assign bus_a.stim_ready = ready;
  assign bus_b.stim_ready = ready;
  assign bus_c.stim_ready = ready;

  stimulus_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INPUT_BASE_ADDR(0), .NUM_WORDS(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a), .busy(busy_a), .load_done(done_a)
`ifdef STIM_CKSUM_EN
    , .stim_cksum(cksum_a)
`endif
  );

  stimulus_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INPUT_BASE_ADDR(2046), .NUM_WORDS(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b), .busy(busy_b), .load_done(done_b)
`ifdef STIM_CKSUM_EN
    , .stim_cksum(cksum_b)
`endif
  );

  stimulus_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INPUT_BASE_ADDR(100), .NUM_WORDS(1)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .bus(bus_c), .busy(busy_c), .load_done(done_c)
`ifdef STIM_CKSUM_EN
    , .stim_cksum(cksum_c)
`endif
  );

  // Synchronous-read memory model: data appears the cycle after rd_en.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) if (bus_a.rd_en) bus_a.mem_data_in <= mem[bus_a.address_out];
  always @(posedge clk) if (bus_b.rd_en) bus_b.mem_data_in <= mem[bus_b.address_out];
  always @(posedge clk) if (bus_c.rd_en) bus_c.mem_data_in <= mem[bus_c.address_out];

  // Outputs of the selected instance.
  logic [AW-1:0] o_addr;
  logic          o_rd, o_valid, o_last, o_busy, o_done;
  logic [DW-1:0] o_data;
`ifdef STIM_CKSUM_EN
  logic [DW-1:0] o_cksum;
`endif

  always_comb begin
    o_addr = bus_a.address_out; o_rd = bus_a.rd_en; o_data = bus_a.stim_data;
    o_valid = bus_a.stim_valid; o_last = bus_a.stim_last; o_busy = busy_a; o_done = done_a;
`ifdef STIM_CKSUM_EN
    o_cksum = cksum_a;
`endif
    if (sel == 1) begin
      o_addr = bus_b.address_out; o_rd = bus_b.rd_en; o_data = bus_b.stim_data;
      o_valid = bus_b.stim_valid; o_last = bus_b.stim_last; o_busy = busy_b; o_done = done_b;
`ifdef STIM_CKSUM_EN
      o_cksum = cksum_b;
`endif
    end else if (sel == 2) begin
      o_addr = bus_c.address_out; o_rd = bus_c.rd_en; o_data = bus_c.stim_data;
      o_valid = bus_c.stim_valid; o_last = bus_c.stim_last; o_busy = busy_c; o_done = done_c;
`ifdef STIM_CKSUM_EN
      o_cksum = cksum_c;
`endif
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard.
  logic [AW-1:0] exp_addr_q [$];
  word_t         exp_word_q [$];
  int            xfer_cnt = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_rd) begin
        if (exp_addr_q.size() == 0) check("unexpected_rd_en", 1, 0);
        else check("rd_address", 32'(o_addr), 32'(exp_addr_q.pop_front()));
      end
      if (o_valid && ready) begin
        if (exp_word_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          word_t w;
          w = exp_word_q.pop_front();
          check("stim_data", 32'(o_data), 32'(w.data));
          check("stim_last", 32'(o_last), 32'(w.last));
        end
        xfer_cnt++;
      end
      if (o_done) done_cnt++;
    end
  end

  // One run on the selected instance. Returns the cycle (relative to the
  // start-sampling edge t0) of the first rd_en, first stim_valid and load_done.
  task automatic run(input int nw, input int base, input int stall_word, input int stall_len,
                     input bit poke, output int t_rd, output int t_val, output int t_done);
    logic [AW-1:0] a;
    logic [DW-1:0] exp_sum;
    int cyc, x0, d0, stall_left;
    bit stalling, poked;
    exp_sum = '0;
    for (int i = 0; i < nw; i++) begin
      a = AW'(base + i);
      exp_addr_q.push_back(a);
      exp_word_q.push_back('{data: mem[a], last: (i == nw - 1)});
      exp_sum = exp_sum + mem[a];
    end
    t_rd = -1; t_val = -1; t_done = -1;
    x0 = xfer_cnt; d0 = done_cnt; stall_left = stall_len; poked = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b1;
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stalling = 1'b0;
      if (poke && o_valid && !poked) begin start = 1'b1; poked = 1'b1; end
      if (poke && o_done) start = 1'b1;
      if (o_valid && (xfer_cnt - x0 == stall_word) && stall_left > 0) begin
        stalling = 1'b1;
        stall_left--;
      end
      ready = !stalling;
      @(negedge clk);
      if (o_rd && t_rd < 0) t_rd = cyc;
      if (o_valid && t_val < 0) t_val = cyc;
`ifdef STIM_CKSUM_EN
      if (cyc == 1) check("cksum_cleared", 32'(o_cksum), 0);
`endif
      if (stalling) begin
        check("stall_valid", 32'(o_valid), 1);
        check("stall_data", 32'(o_data), 32'(mem[AW'(base + stall_word)]));
        check("stall_no_rd", 32'(o_rd), 0);
      end
      if (o_done) begin
        t_done = cyc;
        break;
      end
    end
    if (t_done < 0) check("run_timeout", 1, 0);
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("one_load_done", 32'(done_cnt - d0), 1);
    check("xfer_count", 32'(xfer_cnt - x0), 32'(nw));
    check("addr_q_empty", 32'(exp_addr_q.size()), 0);
    check("word_q_empty", 32'(exp_word_q.size()), 0);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_valid", 32'(o_valid), 0);
    check("idle_last", 32'(o_last), 0);
    check("data_kept", 32'(o_data), 32'(mem[AW'(base + nw - 1)]));
`ifdef STIM_CKSUM_EN
    check("cksum_sum", 32'(o_cksum), 32'(exp_sum));
`endif
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_addr"}, 32'(bus_a.address_out), 0);
    check({tag, "_rd_en"}, 32'(bus_a.rd_en), 0);
    check({tag, "_data"}, 32'(bus_a.stim_data), 0);
    check({tag, "_valid"}, 32'(bus_a.stim_valid), 0);
    check({tag, "_last"}, 32'(bus_a.stim_last), 0);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_rd, t_val, t_done, rd_seen, d0;
    sel = 0; start = 1'b0; ready = 1'b1; reset = 1'b1;
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i * 7 + 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_a_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic run: words 1..4, ready always high.
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    run(4, 0, -1, 0, 1'b0, t_rd, t_val, t_done);
    check("lat_rd_en", 32'(t_rd), 1);
    check("lat_valid", 32'(t_val), 3);
    check("lat_done", 32'(t_done), 13);

    // Backpressure on word 2 for 5 cycles.
    mem[1] = 16'hBEEF;
    run(4, 0, 1, 5, 1'b0, t_rd, t_val, t_done);
    check("stall_done", 32'(t_done), 18);

    // start pulses during PRESENT and during DONE are ignored.
    run(4, 0, -1, 0, 1'b1, t_rd, t_val, t_done);
    check("poke_done", 32'(t_done), 13);

    // Reset during WAIT of word 3.
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(AW'(i));
      exp_word_q.push_back('{data: mem[i], last: (i == 3)});
    end
    d0 = done_cnt;
    rd_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 100 && rd_seen < 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (o_rd) rd_seen++;
    end
    check("reset_reached_word3", 32'(rd_seen), 3);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_a_zero("midrun_reset");
    exp_addr_q.delete();
    exp_word_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt - d0), 0);
    run(4, 0, -1, 0, 1'b0, t_rd, t_val, t_done);

    // Address wrap on instance b: 2046, 2047, 0.
    sel = 1;
    mem[2046] = 16'h1111; mem[2047] = 16'h2222; mem[0] = 16'h3333;
    run(3, 2046, -1, 0, 1'b0, t_rd, t_val, t_done);
    check("wrap_done", 32'(t_done), 10);

    // Single-word run on instance c.
    sel = 2;
    mem[100] = 16'hABCD;
    run(1, 100, -1, 0, 1'b0, t_rd, t_val, t_done);
    check("single_valid", 32'(t_val), 3);
    check("single_done", 32'(t_done), 4);

`ifdef STIM_CKSUM_EN
    // Checksum wraps: 0xFFFF + 0x0002 = 0x0001; a second run clears first.
    sel = 0;
    mem[0] = 16'hFFFF; mem[1] = 16'h0002; mem[2] = 16'h0000; mem[3] = 16'h0000;
    run(4, 0, -1, 0, 1'b0, t_rd, t_val, t_done);
    check("cksum_wrap", 32'(o_cksum), 32'h0001);
    mem[0] = 16'h0010; mem[1] = 16'h0020;
    run(4, 0, -1, 0, 1'b0, t_rd, t_val, t_done);
    check("cksum_second", 32'(o_cksum), 32'h0030);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
